// File: rtl/prt_dptx_trn_pkg.sv
// Shared types and constants for the DP TX training sequencer and its pattern ROM.
// Symbol codes are the 8b values before 8b/10b encoding.
package prt_dptx_trn_pkg;

  localparam logic [7:0] SYM_D10_2 = 8'h4A;
  localparam logic [7:0] SYM_D11_6 = 8'hCB;
  localparam logic [7:0] SYM_K28_5 = 8'hBC;

  localparam int TPS1_LEN = 4;
  localparam int TPS2_LEN = 20;

  typedef enum logic [1:0] {
    TPS_OFF = 2'd0,
    TPS1    = 2'd1,
    TPS2    = 2'd2,
    TPS_RSV = 2'd3
  } tps_e;

  typedef struct packed {
    logic       ctl;
    logic       val;
    logic       k;
    logic [7:0] dat;
  } trn_sym_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_SETTLE,
    ST_SEL
  } trn_st_e;

  function automatic trn_sym_t mk_sym(input logic ctl, input logic val, input logic k,
                                      input logic [7:0] dat);
    trn_sym_t s;
    s.ctl = ctl;
    s.val = val;
    s.k   = k;
    s.dat = dat;
    return s;
  endfunction

endpackage

// File: rtl/prt_dptx_trn_rom.sv
// Training pattern lookup (tps, idx) -> symbol; purely combinational, zero latency.
// No handshake: the caller owns indexing and pacing.
module prt_dptx_trn_rom
  import prt_dptx_trn_pkg::*;
(
  input  logic [1:0] tps,
  input  logic [4:0] idx,
  output trn_sym_t   sym
);

  logic [4:0] pos;

  always_comb begin
    // TPS2 is a 10-symbol sequence sent twice, so fold the second half onto the first.
    pos = (idx >= 5'd10) ? (idx - 5'd10) : idx;
    sym = mk_sym(1'b0, 1'b0, 1'b0, SYM_D10_2);
    if (tps == TPS2) begin
      case (pos)
        5'd0:    sym = mk_sym(1'b1, 1'b0, 1'b1, SYM_K28_5);
        5'd1:    sym = mk_sym(1'b0, 1'b0, 1'b0, SYM_D11_6);
        5'd2:    sym = mk_sym(1'b1, 1'b1, 1'b1, SYM_K28_5);
        5'd3:    sym = mk_sym(1'b0, 1'b0, 1'b0, SYM_D11_6);
        default: sym = mk_sym(1'b0, 1'b0, 1'b0, SYM_D10_2);
      endcase
    end else if (tps != TPS1) begin
      sym = '0;
    end
  end

endmodule

// File: rtl/prt_dptx_trn_ctl.sv
// Training sequencer: streams header + TPS1/TPS2 words, settles, then selects the pattern.
// Req to done = 2 + len + P_SETTLE cycles; stream has no back-pressure, req while busy is dropped.
module prt_dptx_trn_ctl
  import prt_dptx_trn_pkg::*;
#(
  parameter int P_SPL        = 2,
  parameter int P_MSG_DAT    = 16,
  parameter int P_MSG_ID_TPS = 0,
  parameter int P_SETTLE     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_req,
  input  logic [1:0]           cmd_tps,
  output logic                 cmd_busy,
  output logic                 cmd_done,
  output logic                 cmd_err,
  output logic                 trn_first,
  output logic                 trn_last,
  output logic [P_MSG_DAT-1:0] trn_dat,
  output logic                 trn_vld,
  output logic                 ctl_sel,
  output logic [1:0]           sta_tps
);

  // Pattern lengths rounded up to whole lanes' worth of symbols.
  localparam int         LEN1        = ((TPS1_LEN + P_SPL - 1) / P_SPL) * P_SPL;
  localparam int         LEN2        = ((TPS2_LEN + P_SPL - 1) / P_SPL) * P_SPL;
  localparam logic [4:0] LEN1_W      = 5'(LEN1);
  localparam logic [4:0] LEN2_W      = 5'(LEN2);
  localparam logic [3:0] SETTLE_LAST = 4'(P_SETTLE - 1);

  trn_st_e    state;
  logic [1:0] tps_q;
  logic [4:0] idx;
  logic [3:0] cnt;
  logic [4:0] len;
  trn_sym_t   sym;

  assign len = (tps_q == TPS2) ? LEN2_W : LEN1_W;

  prt_dptx_trn_rom u_rom (
    .tps (tps_q),
    .idx (idx),
    .sym (sym)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tps_q     <= 2'd0;
      idx       <= '0;
      cnt       <= '0;
      cmd_busy  <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      trn_first <= 1'b0;
      trn_last  <= 1'b0;
      trn_dat   <= '0;
      trn_vld   <= 1'b0;
      ctl_sel   <= 1'b0;
      sta_tps   <= 2'd0;
    end else begin
      cmd_done  <= 1'b0;
      trn_first <= 1'b0;
      trn_last  <= 1'b0;
      trn_vld   <= 1'b0;
      trn_dat   <= '0;
      case (state)
        // SEL already has busy low, so it accepts a new command just like IDLE.
        ST_IDLE, ST_SEL: begin
          state <= ST_IDLE;
          if (cmd_req) begin
            case (cmd_tps)
              TPS1, TPS2: begin
                tps_q     <= cmd_tps;
                cmd_busy  <= 1'b1;
                cmd_err   <= 1'b0;
                trn_vld   <= 1'b1;
                trn_first <= 1'b1;
                trn_dat   <= P_MSG_DAT'(P_MSG_ID_TPS);
                state     <= ST_HDR;
              end
              TPS_OFF: begin
                ctl_sel  <= 1'b0;
                sta_tps  <= 2'd0;
                cmd_err  <= 1'b0;
                cmd_done <= 1'b1;
              end
              default: begin
                cmd_err  <= 1'b1;
                cmd_done <= 1'b1;
              end
            endcase
          end
        end
        ST_HDR, ST_LOAD: begin
          if (idx == len) begin
            idx   <= '0;
            cnt   <= '0;
            state <= ST_SETTLE;
          end else begin
            trn_vld  <= 1'b1;
            trn_dat  <= {{(P_MSG_DAT-11){1'b0}}, sym};
            trn_last <= (idx == len - 5'd1);
            idx      <= idx + 5'd1;
            state    <= ST_LOAD;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt      <= '0;
            ctl_sel  <= 1'b1;
            sta_tps  <= tps_q;
            cmd_done <= 1'b1;
            cmd_busy <= 1'b0;
            state    <= ST_SEL;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prt_dptx_trn_ctl.sv
// Scoreboard bench for prt_dptx_trn_ctl: stimulus queues expected words/done states,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_prt_dptx_trn_ctl;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        cmd_req = 1'b0;
  logic [1:0]  cmd_tps = 2'd0;
  logic        cmd_busy, cmd_done, cmd_err, trn_first, trn_last, trn_vld, ctl_sel;
  logic [15:0] trn_dat;
  logic [1:0]  sta_tps;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_w[$];   // {first, last, dat}
  logic [3:0]  exp_d[$];   // {ctl_sel, sta_tps, err} on the done cycle
  logic [15:0] tps2_tab[10];

  always #5 clk = ~clk;

  prt_dptx_trn_ctl #(
    .P_SPL(2), .P_MSG_DAT(16), .P_MSG_ID_TPS(0), .P_SETTLE(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_req   (cmd_req),
    .cmd_tps   (cmd_tps),
    .cmd_busy  (cmd_busy),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err),
    .trn_first (trn_first),
    .trn_last  (trn_last),
    .trn_dat   (trn_dat),
    .trn_vld   (trn_vld),
    .ctl_sel   (ctl_sel),
    .sta_tps   (sta_tps)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_words(input logic [1:0] tps);
    int len;
    logic [15:0] w;
    len = (tps == 2'd2) ? 20 : 4;
    exp_w.push_back({1'b1, 1'b0, 16'h0000});
    for (int i = 0; i < len; i++) begin
      w = (tps == 2'd2) ? tps2_tab[i % 10] : 16'h004A;
      exp_w.push_back({1'b0, (i == len - 1), w});
    end
  endtask

  // Issue one command and wait (bounded) for done; poke fires a reserved req while busy,
  // hold demands ctl_sel=1 and sta_tps=hold_sta until done.
  task automatic issue(input logic [1:0] tps, input int exp_lat, input logic [3:0] exp_done,
                       input bit poke, input bit hold, input logic [1:0] hold_sta);
    int n;
    bit hold_ok;
    hold_ok = 1'b1;
    if (tps == 2'd1 || tps == 2'd2) push_words(tps);
    exp_d.push_back(exp_done);
    @(posedge clk); #1;
    cmd_req = 1'b1;
    cmd_tps = tps;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        cmd_req = 1'b0;
        chk("busy_set", int'(cmd_busy), int'(tps == 2'd1 || tps == 2'd2));
      end
      if (poke && n == 2) begin
        cmd_req = 1'b1;
        cmd_tps = 2'd3;
      end
      if (poke && n == 3) cmd_req = 1'b0;
      if (cmd_done) break;
      if (hold && (ctl_sel !== 1'b1 || sta_tps !== hold_sta)) hold_ok = 1'b0;
    end
    chk("latency", n, exp_lat);
    chk("busy_clr", int'(cmd_busy), 0);
    if (hold) chk("sel_hold", int'(hold_ok), 1);
  endtask

  // Monitor: every presented word / done pulse is matched against the scoreboard.
  initial begin
    logic [17:0] ew;
    logic [3:0]  ed;
    forever begin
      @(negedge clk);
      if (trn_vld) begin
        if (exp_w.size() == 0) begin
          chk("word_unexpected", int'({trn_first, trn_last, trn_dat}), -1);
        end else begin
          ew = exp_w.pop_front();
          chk("word", int'({trn_first, trn_last, trn_dat}), int'(ew));
        end
      end
      if (cmd_done) begin
        if (exp_d.size() == 0) begin
          chk("done_unexpected", int'({ctl_sel, sta_tps, cmd_err}), -1);
        end else begin
          ed = exp_d.pop_front();
          chk("done_state", int'({ctl_sel, sta_tps, cmd_err}), int'(ed));
        end
      end
    end
  end

  initial begin
    // K28.5 carries k=1: {ctl,val,k} = 101 -> 0x5BC, 111 -> 0x7BC.
    tps2_tab[0] = 16'h05BC;
    tps2_tab[1] = 16'h00CB;
    tps2_tab[2] = 16'h07BC;
    tps2_tab[3] = 16'h00CB;
    for (int i = 4; i < 10; i++) tps2_tab[i] = 16'h004A;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({cmd_busy, cmd_done, cmd_err, trn_first, trn_last, trn_vld,
                               ctl_sel, sta_tps, trn_dat}), 0);
    rst_n = 1'b1;

    // TPS1 with a reserved req poked while busy: ignored, no error.
    issue(2'd1, 10, {1'b1, 2'd1, 1'b0}, 1'b1, 1'b0, 2'd0);
    chk("err_after_poke", int'(cmd_err), 0);

    // TPS1 -> TPS2 switch, then an identical TPS2 reload; link stays selected.
    issue(2'd2, 26, {1'b1, 2'd2, 1'b0}, 1'b0, 1'b1, 2'd1);
    issue(2'd2, 26, {1'b1, 2'd2, 1'b0}, 1'b0, 1'b1, 2'd2);

    // Reserved pattern: error, done, link untouched; then a legal command clears it.
    issue(2'd3, 1, {1'b1, 2'd2, 1'b1}, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    chk("err_sticky", int'(cmd_err), 1);
    issue(2'd1, 10, {1'b1, 2'd1, 1'b0}, 1'b0, 1'b1, 2'd2);
    chk("err_cleared", int'(cmd_err), 0);

    // Back to main link: immediate, no message.
    issue(2'd0, 1, {1'b0, 2'd0, 1'b0}, 1'b0, 1'b0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("off_sel", int'({ctl_sel, sta_tps}), 0);

    // Reset in the middle of a TPS2 load.
    push_words(2'd2);
    exp_d.push_back({1'b1, 2'd2, 1'b0});
    @(posedge clk); #1;
    cmd_req = 1'b1;
    cmd_tps = 2'd2;
    @(posedge clk); #1;
    cmd_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_vld", int'(trn_vld), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async", int'({cmd_busy, cmd_done, cmd_err, trn_first, trn_last, trn_vld,
                           ctl_sel, sta_tps, trn_dat}), 0);
    exp_w.delete();
    exp_d.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(2'd1, 10, {1'b1, 2'd1, 1'b0}, 1'b0, 1'b0, 2'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("words_drained", exp_w.size(), 0);
    chk("dones_drained", exp_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
